arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Upstream request stage for the 2-way arbiter: two per-requester FIFOs hold pending transactions.
- Drives the arbiter's 2-bit request vector from FIFO occupancy and consumes the 2-bit grant.
- Pops the granted FIFO and presents the popped transaction, tagged with its requester ID, to the downstream consumer.
- request is registered from next-state occupancy, so a correctly behaving arbiter can never grant an empty queue.

Parameters:
- DW, 8, payload width per transaction.
- DEPTH, 4, entries per FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset; 0 = asserted, released synchronously to clk.
- push0_valid  input  1  requester 0 offers a transaction.
- push0_data  input  DW  requester 0 payload.
- push0_ready  output  1  FIFO0 can accept; high when count0 < DEPTH.
- push1_valid  input  1  requester 1 offers a transaction.
- push1_data  input  DW  requester 1 payload.
- push1_ready  output  1  FIFO1 can accept; high when count1 < DEPTH.
- request  output  2  to arbiter; bit i = FIFO i holds an entry.
- grant  input  2  from arbiter; one-hot or zero.
- out_valid  output  1  one-cycle pulse, popped transaction valid.
- out_data  output  DW  popped payload.
- out_id  output  1  requester index of the popped payload.
- error  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset = 0, asynchronous):
  - counts, pointers, request, out_valid, out_id and error go to 0; out_data goes to 0.
  - push0_ready and push1_ready = 1 once reset is released.
- Push: push i is accepted at posedge when pushi_valid && pushi_ready.
  - pushi_ready is combinational: counti < DEPTH.
  - A pop in the same cycle does not raise ready; full stays non-accepting for that cycle.
- Pop: at posedge, if grant == 2'b01 and count0 > 0, pop FIFO0; likewise grant == 2'b10 with FIFO1.
  - Next cycle: out_valid = 1, out_data = head entry, out_id = i.
  - Latency is 1 cycle from the grant-sampling edge to out_valid.
  - No backpressure on the output: the consumer must accept every out_valid pulse.
- request is registered:
  - request[i] <= (counti_next != 0), where counti_next includes this cycle's push and pop.
  - A push into an empty FIFO raises request[i] on the following edge; with the arbiter's registered grant, the earliest grant arrives 2 cycles after the push edge.
  - Popping the last entry drops request[i] in the same edge the pop occurs.
- Simultaneous push and pop on the same FIFO:
  - count unchanged.
  - The pushed entry is written at the tail, the head is read; both are legal at any non-empty count.
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Errors (sticky until reset; no pop, state unchanged):
  - grant == 2'b11.
  - grant[i] == 1 with counti == 0.
- Order: each FIFO is strict FIFO. Relative order between the two FIFOs is set solely by grant order.
- Reset mid-operation: all queued entries are discarded, and request, out_valid and error drop immediately (asynchronously).

Test Plan:
1. Reset held 10 cycles, then released:
   - During reset: request = 00, out_valid = 0, error = 0.
   - After release: push0_ready = push1_ready = 1.
2. Push 0xA5 on ch0 with grant = 00:
   - Next edge: request = 01.
   - Drive grant = 01 one cycle: next cycle out_valid = 1, out_data = 0xA5, out_id = 0, then request = 00.
3. Push 4 entries (0x01..0x04) into ch1 with grant held 00:
   - push1_ready = 0 after the 4th.
   - A 5th push is refused.
   - Four grant = 10 cycles produce out_data 0x01, 0x02, 0x03, 0x04 in order.
   - push1_ready returns to 1 after the first pop.
4. FIFO0 at count 2, push0 and grant = 01 in the same cycle:
   - count stays 2, push0_ready stays 1.
   - Popped data is the oldest entry.
   - Wrap-around verified over 3×DEPTH transactions.
5. Drive grant = 11, or grant = 10 while FIFO1 is empty:
   - error = 1 next cycle and stays 1.
   - No out_valid pulse; counts unchanged.
6. Random pushes on both channels with the real arbiter attached, reset asserted mid-stream for 3 cycles:
   - request = 00 and out_valid = 0 immediately.
   - After release, no stale data is emitted.
   - Every pushed payload after release appears exactly once on out_data.

Source files
------------

// File: rtl/arb_req_queue.sv
// Upstream request stage for a 2-way arbiter: two per-requester FIFOs,
// a registered request vector, and a one-cycle tagged output pulse.
module arb_req_queue #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0_valid,
  input  logic [DW-1:0] push0_data,
  output logic          push0_ready,
  input  logic          push1_valid,
  input  logic [DW-1:0] push1_data,
  output logic          push1_ready,
  output logic [1:0]    request,
  input  logic [1:0]    grant,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_id,
  output logic          error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [CW-1:0] cnt0, cnt1;
  logic [CW-1:0] cnt0_nx, cnt1_nx;
  logic          psh0, psh1;
  logic          pop0, pop1;
  logic          bad;

  assign push0_ready = cnt0 < FULL;
  assign push1_ready = cnt1 < FULL;
  assign psh0 = push0_valid && push0_ready;
  assign psh1 = push1_valid && push1_ready;

  // An illegal grant pops nothing; it only latches the error flag.
  always_comb begin
    bad  = 1'b0;
    pop0 = 1'b0;
    pop1 = 1'b0;
    unique case (grant)
      2'b01: begin
        if (cnt0 == '0) bad = 1'b1;
        else pop0 = 1'b1;
      end
      2'b10: begin
        if (cnt1 == '0) bad = 1'b1;
        else pop1 = 1'b1;
      end
      2'b11: bad = 1'b1;
      default: ;
    endcase
  end

  assign cnt0_nx = cnt0 + CW'(psh0) - CW'(pop0);
  assign cnt1_nx = cnt1 + CW'(psh1) - CW'(pop1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0      <= '0;
      cnt1      <= '0;
      wp0       <= '0;
      rp0       <= '0;
      wp1       <= '0;
      rp1       <= '0;
      request   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      error     <= 1'b0;
    end else begin
      cnt0 <= cnt0_nx;
      cnt1 <= cnt1_nx;
      if (psh0) wp0 <= wp0 + 1'b1;
      if (psh1) wp1 <= wp1 + 1'b1;
      if (pop0) rp0 <= rp0 + 1'b1;
      if (pop1) rp1 <= rp1 + 1'b1;
      // Next-state occupancy keeps a registered arbiter off empty queues.
      request   <= {cnt1_nx != '0, cnt0_nx != '0};
      out_valid <= pop0 | pop1;
      if (pop0) begin
        out_data <= mem0[rp0];
        out_id   <= 1'b0;
      end else if (pop1) begin
        out_data <= mem1[rp1];
        out_id   <= 1'b1;
      end
      if (bad) error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (psh0) mem0[wp0] <= push0_data;
    if (psh1) mem1[wp1] <= push1_data;
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed and randomized bench for arb_req_queue against a queue-based
// model, with a registered round-robin arbiter for the random phase.
module tb_arb_req_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push0_valid = 1'b0;
  logic          push1_valid = 1'b0;
  logic [DW-1:0] push0_data = '0;
  logic [DW-1:0] push1_data = '0;
  logic          push0_ready, push1_ready;
  logic [1:0]    request, grant;
  logic          out_valid, out_id, error;
  logic [DW-1:0] out_data;

  logic [1:0] man_g = 2'b00;
  logic [1:0] arb_g;
  logic       arb_last;
  logic       arb_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_err = 1'b0;
  logic          m_ov = 1'b0;
  logic          m_id = 1'b0;
  logic [DW-1:0] m_data = '0;

  always #5 clk = ~clk;

  assign grant = arb_on ? arb_g : man_g;

  arb_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .push0_valid(push0_valid),
    .push0_data(push0_data),
    .push0_ready(push0_ready),
    .push1_valid(push1_valid),
    .push1_data(push1_data),
    .push1_ready(push1_ready),
    .request(request),
    .grant(grant),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_id(out_id),
    .error(error)
  );

  // Registered round-robin arbiter; idles one cycle after each grant
  // so it always sees the post-pop request before granting again.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_g    <= 2'b00;
      arb_last <= 1'b1;
    end else if (!arb_on || arb_g != 2'b00) begin
      arb_g <= 2'b00;
    end else if (request == 2'b11) begin
      arb_g    <= arb_last ? 2'b01 : 2'b10;
      arb_last <= ~arb_last;
    end else begin
      arb_g <= request;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("request", 32'(request),
        32'({q1.size() != 0, q0.size() != 0}));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_id", 32'(out_id), 32'(m_id));
    end
    chk("error", 32'(error), 32'(m_err));
    chk("push0_ready", 32'(push0_ready), 32'(q0.size() < DEPTH));
    chk("push1_ready", 32'(push1_ready), 32'(q1.size() < DEPTH));
  endtask

  task automatic step(input logic v0, input logic [DW-1:0] d0,
                      input logic v1, input logic [DW-1:0] d1,
                      input logic [1:0] mg);
    logic       a0, a1, bad;
    logic [1:0] g;
    push0_valid = v0;
    push0_data  = d0;
    push1_valid = v1;
    push1_data  = d1;
    man_g       = mg;
    #1;
    g    = grant;
    m_ov = 1'b0;
    if (reset) begin
      a0  = v0 && (q0.size() < DEPTH);
      a1  = v1 && (q1.size() < DEPTH);
      bad = (g == 2'b11) || (g[0] && q0.size() == 0) ||
            (g[1] && q1.size() == 0);
      if (bad) begin
        m_err = 1'b1;
      end else if (g == 2'b01) begin
        m_data = q0.pop_front();
        m_id   = 1'b0;
        m_ov   = 1'b1;
      end else if (g == 2'b10) begin
        m_data = q1.pop_front();
        m_id   = 1'b1;
        m_ov   = 1'b1;
      end
      if (a0) q0.push_back(d0);
      if (a1) q1.push_back(d1);
    end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_err = 1'b0;
    m_ov  = 1'b0;
  endtask

  initial begin
    // 1: reset held for 10 cycles
    @(negedge clk);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 2'b00);
    chk("rst_out_data", 32'(out_data), 32'h0);
    reset = 1'b1;
    step(0, 0, 0, 0, 2'b00);

    // 2: single push then single grant
    step(1, 8'hA5, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b01);
    step(0, 0, 0, 0, 2'b00);

    // 3: fill ch1, refuse a fifth push, drain in order
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 8'(i), 2'b00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2'b10);
    step(0, 0, 0, 0, 2'b00);

    // 4: ch0 held at two entries with push+pop, wrapping pointers
    step(1, 8'h10, 0, 0, 2'b00);
    step(1, 8'h11, 0, 0, 2'b00);
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1, 8'(8'h20 + i), 0, 0, 2'b01);

    // 5: illegal grants set the sticky error and pop nothing
    step(0, 0, 0, 0, 2'b11);
    step(0, 0, 0, 0, 2'b10);
    step(0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b01);
    step(0, 0, 0, 0, 2'b01);
    step(0, 0, 0, 0, 2'b00);

    // 6: random traffic through the arbiter with a mid-stream reset
    arb_on = 1'b1;
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom), 2'b00);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    chk("async_request", 32'(request), 32'h0);
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_error", 32'(error), 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom), 2'b00);
    reset = 1'b1;
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom), 2'b00);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 2'b00);
    chk("drained_request", 32'(request), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
